stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Stack-pointer register and stack-memory sequencer for the CPU datapath.
- Holds SP and executes push/pop commands from the control unit.
- Drives a req/ack handshake to data memory and reports completion, full/empty state and overflow/underflow errors.
- The stack grows downward; SP always points at the top-of-stack entry.

Parameters:
W, 16, data and address width
SP_INIT, 16'h0100, SP reset value; stack is empty when SP==SP_INIT
SP_LIMIT, 16'h00FC, lowest legal SP; stack is full when SP==SP_LIMIT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
push  in  1  push request; sampled only in IDLE
pop  in  1  pop request; sampled only in IDLE
push_data  in  W  word to push
err_clr  in  1  clears sticky ovf/udf
mem_req  out  1  memory request, held until ack
mem_we  out  1  1=write (push), 0=read (pop)
mem_addr  out  W  memory address
mem_wdata  out  W  write data
mem_rdata  in  W  read data, valid with mem_ack
mem_ack  in  1  memory completion, 1-cycle pulse
pop_data  out  W  last popped word
sp  out  W  current stack pointer
busy  out  1  high while not IDLE
done  out  1  1-cycle pulse at command completion
err  out  1  1-cycle pulse with done when a command was rejected
full  out  1  sp==SP_LIMIT (combinational from sp)
empty  out  1  sp==SP_INIT (combinational from sp)
ovf  out  1  sticky overflow flag
udf  out  1  sticky underflow flag

Behaviour:
- Reset (async, takes effect immediately):
  - sp=SP_INIT, state=IDLE.
  - mem_req, mem_we, done, err, ovf, udf all 0.
  - mem_addr, mem_wdata and pop_data all 0.
- States: IDLE, MEM.
  - busy = (state==MEM).
  - All outputs except full/empty are registered.
- IDLE, push=1 and not full, at the accepting edge:
  - sp<=sp-1 and mem_addr<=sp-1.
  - mem_wdata<=push_data, mem_we<=1, mem_req<=1.
  - state<=MEM.
- IDLE, pop=1 (push=0) and not empty, at the accepting edge:
  - mem_addr<=sp, mem_we<=0, mem_req<=1.
  - state<=MEM.
- Simultaneous push and pop: push wins; pop is ignored, with no error.
- Rejected push (full): no memory access, sp unchanged, done<=1, err<=1, ovf<=1; state stays IDLE.
- Rejected pop (empty): same as a rejected push, but sets udf.
- MEM, edge where mem_ack=1:
  - mem_req<=0, done<=1, state<=IDLE.
  - On a pop, also pop_data<=mem_rdata and sp<=sp+1.
- MEM with mem_ack=0:
  - Hold all memory outputs stable.
  - No timeout.
  - push/pop inputs are ignored (not queued).
- mem_ack while IDLE: ignored.
- Latency:
  - Command accepted at edge N.
  - Zero-wait ack sampled at edge N+1.
  - done is high during the cycle after edge N+1.
  - The next command is accepted at edge N+2.
  - A rejected command gives done/err in the cycle after edge N.
- err_clr: clears ovf/udf at the next edge. If a new error occurs on that same edge, the set takes priority.
- done and err are low on every cycle not listed above.
- Arithmetic: SP inc/dec is modulo 2^W. The full/empty guards keep SP inside [SP_LIMIT, SP_INIT].
- Reset during MEM: mem_req drops asynchronously; the operation is abandoned and sp returns to SP_INIT.

Decomposition:
- Shared package cpu_pkg: state enum (IDLE, MEM) and the width constant W.
- One natural sub-module: sp_step, a combinational W-bit ±1 unit (inputs sp and dir; output sp_next). It is shared by the push and pop paths.
- FSM, registers and flags stay in stack_ctrl.

Test Plan:
1. Reset, then push=1 with push_data=16'h1015, memory acks 1 cycle after req -> mem_addr=16'h00FF, mem_we=1, mem_wdata=16'h1015; sp=16'h00FF; one done pulse; err=0.
2. Push 16'hABA2 with mem_ack delayed 3 cycles, then pop with mem_rdata=16'hABA2 -> busy high 4 cycles; mem_* stable while waiting; after the pop, pop_data=16'hABA2 and sp=16'h00FF.
3. Four pushes to full (sp=16'h00FC, full=1), then a fifth push -> no mem_req; done=1 and err=1 for one cycle; ovf=1 sticky; sp unchanged.
4. Pop from reset (empty=1) -> no mem_req; err pulse; udf=1. Then err_clr=1 for one cycle -> udf=0.
5. push=1 and pop=1 in the same IDLE cycle -> push is performed (mem_we=1); no err.
6. rst asserted while mem_req=1 and before ack -> mem_req=0 immediately; sp=16'h0100; busy=0. A later ack is ignored, and pop_data stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: datapath width and the stack sequencer state encoding.
package cpu_pkg;

    localparam int W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        MEM  = 1'b1
    } stack_state_t;

endpackage

// File: rtl/sp_step.sv
// Combinational W-bit stack-pointer step unit: dir=1 decrements (push), dir=0 increments (pop).
module sp_step #(
    parameter int W = cpu_pkg::W
) (
    input  logic [W-1:0] sp,
    input  logic         dir,
    output logic [W-1:0] sp_next
);

    // Wraps modulo 2^W; the caller's full/empty guards keep sp in range.
    assign sp_next = dir ? (sp - W'(1)) : (sp + W'(1));

endmodule

// File: rtl/stack_ctrl.sv
// Stack-pointer register and push/pop sequencer driving a req/ack data-memory port.
module stack_ctrl
    import cpu_pkg::*;
#(
    parameter int         W        = cpu_pkg::W,
    parameter logic [W-1:0] SP_INIT  = 16'h0100,
    parameter logic [W-1:0] SP_LIMIT = 16'h00FC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    input  logic         err_clr,
    output logic         mem_req,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic [W-1:0] pop_data,
    output logic [W-1:0] sp,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         full,
    output logic         empty,
    output logic         ovf,
    output logic         udf
);

    stack_state_t state, state_n;
    logic [W-1:0] sp_n, sp_stepped, mem_addr_n, mem_wdata_n, pop_data_n;
    logic         mem_req_n, mem_we_n, done_n, err_n, ovf_n, udf_n;

    // One adder serves both paths: decrement while accepting a push in IDLE,
    // increment when a pop completes in MEM.
    sp_step #(.W(W)) u_sp_step (
        .sp      (sp),
        .dir     (state == IDLE),
        .sp_next (sp_stepped)
    );

    assign full  = (sp == SP_LIMIT);
    assign empty = (sp == SP_INIT);
    assign busy  = (state == MEM);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_n     = state;
        sp_n        = sp;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        pop_data_n  = pop_data;
        done_n      = 1'b0;
        err_n       = 1'b0;
        ovf_n       = err_clr ? 1'b0 : ovf;
        udf_n       = err_clr ? 1'b0 : udf;

        unique case (state)
            IDLE: begin
                if (push) begin
                    if (!full) begin
                        sp_n        = sp_stepped;
                        mem_addr_n  = sp_stepped;
                        mem_wdata_n = push_data;
                        mem_we_n    = 1'b1;
                        mem_req_n   = 1'b1;
                        state_n     = MEM;
                    end else begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                        ovf_n  = 1'b1;
                    end
                end else if (pop) begin
                    if (!empty) begin
                        mem_addr_n = sp;
                        mem_we_n   = 1'b0;
                        mem_req_n  = 1'b1;
                        state_n    = MEM;
                    end else begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                        udf_n  = 1'b1;
                    end
                end
            end
            MEM: begin
                if (mem_ack) begin
                    mem_req_n = 1'b0;
                    done_n    = 1'b1;
                    state_n   = IDLE;
                    if (!mem_we) begin
                        pop_data_n = mem_rdata;
                        sp_n       = sp_stepped;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sp        <= SP_INIT;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pop_data  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_n;
            sp        <= sp_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            pop_data  <= pop_data_n;
            done      <= done_n;
            err       <= err_n;
            ovf       <= ovf_n;
            udf       <= udf_n;
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl: push/pop handshakes, full/empty rejection, flags, reset abort.
module tb_stack_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         push = 1'b0, pop = 1'b0, err_clr = 1'b0, mem_ack = 1'b0;
    logic [W-1:0] push_data = '0, mem_rdata = '0;
    logic         mem_req, mem_we, busy, done, err, full, empty, ovf, udf;
    logic [W-1:0] mem_addr, mem_wdata, pop_data, sp;

    int checks = 0;
    int errors = 0;
    int busy_cycles;

    always #5 clk = ~clk;

    stack_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .err_clr   (err_clr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pop_data  (pop_data),
        .sp        (sp),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .udf       (udf)
    );

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push with a zero-wait ack; leaves the bench just after the ack edge.
    task automatic do_push(input logic [W-1:0] data, input logic [W-1:0] exp_sp);
        push = 1'b1; push_data = data;
        step();
        push = 1'b0;
        check("push_req", {15'd0, mem_req}, 16'd1);
        check("push_sp", sp, exp_sp);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("push_done", {15'd0, done}, 16'd1);
    endtask

    task automatic do_pop(input logic [W-1:0] rdata, input logic [W-1:0] exp_sp);
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("pop_req", {15'd0, mem_req}, 16'd1);
        mem_ack = 1'b1; mem_rdata = rdata;
        step();
        mem_ack = 1'b0;
        check("pop_done", {15'd0, done}, 16'd1);
        check("pop_data", pop_data, rdata);
        check("pop_sp", sp, exp_sp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12 rst = 1'b0;
        #1;
        check("rst_sp", sp, 16'h0100);
        check("rst_empty", {15'd0, empty}, 16'd1);
        check("rst_full", {15'd0, full}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_req", {15'd0, mem_req}, 16'd0);
        check("rst_flags", {12'd0, done, err, ovf, udf}, 16'd0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_pop_data", pop_data, 16'h0000);

        // Pop from empty: rejected, udf set; err_clr clears it
        step();
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("udf_req", {15'd0, mem_req}, 16'd0);
        check("udf_done", {15'd0, done}, 16'd1);
        check("udf_err", {15'd0, err}, 16'd1);
        check("udf_set", {15'd0, udf}, 16'd1);
        check("udf_sp", sp, 16'h0100);
        step();
        check("udf_done_low", {15'd0, done}, 16'd0);
        check("udf_err_low", {15'd0, err}, 16'd0);
        check("udf_sticky", {15'd0, udf}, 16'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("udf_clr", {15'd0, udf}, 16'd0);

        // First push, ack one cycle after req
        push = 1'b1; push_data = 16'h1015;
        step();
        push = 1'b0;
        check("p1_req", {15'd0, mem_req}, 16'd1);
        check("p1_we", {15'd0, mem_we}, 16'd1);
        check("p1_addr", mem_addr, 16'h00FF);
        check("p1_wdata", mem_wdata, 16'h1015);
        check("p1_sp", sp, 16'h00FF);
        check("p1_busy", {15'd0, busy}, 16'd1);
        check("p1_done_early", {15'd0, done}, 16'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("p1_req_drop", {15'd0, mem_req}, 16'd0);
        check("p1_done", {15'd0, done}, 16'd1);
        check("p1_err", {15'd0, err}, 16'd0);
        check("p1_idle", {15'd0, busy}, 16'd0);
        step();
        check("p1_done_pulse", {15'd0, done}, 16'd0);

        // Push with 3-cycle ack delay; inputs during MEM are ignored
        push = 1'b1; push_data = 16'hABA2;
        step();
        busy_cycles = 1;
        push_data = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy) busy_cycles++;
            check("p2_hold_req", {15'd0, mem_req}, 16'd1);
            check("p2_hold_addr", mem_addr, 16'h00FE);
            check("p2_hold_wdata", mem_wdata, 16'hABA2);
            check("p2_hold_sp", sp, 16'h00FE);
        end
        push = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        if (busy) busy_cycles++;
        check("p2_busy_cycles", 16'(busy_cycles), 16'd4);
        check("p2_done", {15'd0, done}, 16'd1);
        check("p2_sp", sp, 16'h00FE);

        // Pop it back
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("pp_we", {15'd0, mem_we}, 16'd0);
        check("pp_addr", mem_addr, 16'h00FE);
        check("pp_sp_wait", sp, 16'h00FE);
        mem_ack = 1'b1; mem_rdata = 16'hABA2;
        step();
        mem_ack = 1'b0;
        check("pp_pop_data", pop_data, 16'hABA2);
        check("pp_sp", sp, 16'h00FF);

        // Back to empty, then four pushes to full
        do_pop(16'h1015, 16'h0100);
        check("empty_again", {15'd0, empty}, 16'd1);
        do_push(16'h0001, 16'h00FF);
        do_push(16'h0002, 16'h00FE);
        do_push(16'h0003, 16'h00FD);
        do_push(16'h0004, 16'h00FC);
        check("full_flag", {15'd0, full}, 16'd1);

        // Overflow: rejected push
        push = 1'b1; push_data = 16'hDEAD;
        step();
        push = 1'b0;
        check("ovf_req", {15'd0, mem_req}, 16'd0);
        check("ovf_done", {15'd0, done}, 16'd1);
        check("ovf_err", {15'd0, err}, 16'd1);
        check("ovf_set", {15'd0, ovf}, 16'd1);
        check("ovf_sp", sp, 16'h00FC);
        step();
        check("ovf_err_low", {15'd0, err}, 16'd0);
        check("ovf_sticky", {15'd0, ovf}, 16'd1);

        // err_clr on the same edge as a new overflow: set wins
        err_clr = 1'b1; push = 1'b1;
        step();
        err_clr = 1'b0; push = 1'b0;
        check("ovf_set_priority", {15'd0, ovf}, 16'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovf_clr", {15'd0, ovf}, 16'd0);

        // Simultaneous push and pop: push wins, no error
        do_pop(16'h0004, 16'h00FD);
        push = 1'b1; pop = 1'b1; push_data = 16'h7777;
        step();
        push = 1'b0; pop = 1'b0;
        check("both_we", {15'd0, mem_we}, 16'd1);
        check("both_addr", mem_addr, 16'h00FC);
        check("both_sp", sp, 16'h00FC);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("both_done", {15'd0, done}, 16'd1);
        check("both_err", {15'd0, err}, 16'd0);

        // Reset in the middle of a pop: abandoned, later ack ignored
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("abort_req_before", {15'd0, mem_req}, 16'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_req", {15'd0, mem_req}, 16'd0);
        check("abort_sp", sp, 16'h0100);
        check("abort_busy", {15'd0, busy}, 16'd0);
        #2 rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        check("abort_pop_data", pop_data, 16'h0000);
        check("abort_done", {15'd0, done}, 16'd0);
        check("abort_sp_after", sp, 16'h0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
